// File: rtl/regfile_write_arbiter.sv
// Two-port writeback arbiter in front of the register file write port.
// One holding slot per port; age breaks same-register ties, round-robin otherwise.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 req0_valid,
  input  logic [ADDR_W-1:0]    req0_reg,
  input  logic [DATA_W-1:0]    req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_W-1:0]    req1_reg,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 req1_ready,
  output logic                 regWrite,
  output logic [ADDR_W-1:0]    writeReg,
  output logic [DATA_W-1:0]    writeData,
  output logic [2**ADDR_W-1:0] pending
);

  logic              full0, full1;
  logic [ADDR_W-1:0] reg0, reg1;
  logic [DATA_W-1:0] data0, data1;
  logic              older;
  logic              last_grant;
  logic              gnt_any, gnt_sel;
  logic              gnt0, gnt1;
  logic              fill0, fill1;

  // older: 0 = slot 0 holds the older entry
  always_comb begin
    gnt_any = full0 | full1;
    gnt_sel = 1'b0;
    if (full0 && full1)
      gnt_sel = (reg0 == reg1) ? older : !last_grant;
    else if (full1)
      gnt_sel = 1'b1;
  end

  assign gnt0 = gnt_any && !gnt_sel;
  assign gnt1 = gnt_any && gnt_sel;

  assign req0_ready = !Rst && (!full0 || gnt0);
  assign req1_ready = !Rst && (!full1 || gnt1);

  assign fill0 = req0_valid && req0_ready && (req0_reg != '0);
  assign fill1 = req1_valid && req1_ready && (req1_reg != '0);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      full0      <= 1'b0;
      full1      <= 1'b0;
      reg0       <= '0;
      reg1       <= '0;
      data0      <= '0;
      data1      <= '0;
      older      <= 1'b0;
      last_grant <= 1'b1;
      regWrite   <= 1'b0;
      writeReg   <= '0;
      writeData  <= '0;
    end else begin
      if (fill0) begin
        full0 <= 1'b1;
        reg0  <= req0_reg;
        data0 <= req0_data;
      end else if (gnt0) begin
        full0 <= 1'b0;
      end
      if (fill1) begin
        full1 <= 1'b1;
        reg1  <= req1_reg;
        data1 <= req1_data;
      end else if (gnt1) begin
        full1 <= 1'b0;
      end
      if (fill0)
        older <= !fill1;
      else if (fill1)
        older <= 1'b0;
      if (gnt_any) begin
        last_grant <= gnt_sel;
        regWrite   <= 1'b1;
        writeReg   <= gnt_sel ? reg1 : reg0;
        writeData  <= gnt_sel ? data1 : data0;
      end else begin
        regWrite   <= 1'b0;
      end
    end
  end

  always_comb begin
    pending = '0;
    if (full0)
      pending[reg0] = 1'b1;
    if (full1)
      pending[reg1] = 1'b1;
    if (regWrite)
      pending[writeReg] = 1'b1;
    pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed stimulus, expected writes
// queued in order, a negedge monitor pops and compares each write.
module tb_regfile_write_arbiter;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_reg, req1_reg;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [31:0] pending;

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clk(Clk), .Rst(Rst),
    .req0_valid(req0_valid), .req0_reg(req0_reg),
    .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .pending(pending)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];

  logic [31:0] rf [32] = '{default: 32'h0};

  always @(posedge Clk)
    if (!Rst && regWrite && writeReg != 5'd0)
      rf[writeReg] <= writeData;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.r = r;
    e.d = d;
    exp_q.push_back(e);
  endtask

  wr_t got;
  always @(negedge Clk) begin
    if (!Rst && regWrite) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got r%0d=%h expected none",
                 writeReg, writeData);
      end else begin
        got = exp_q.pop_front();
        chk("wr_reg", 32'(writeReg), 32'(got.r));
        chk("wr_data", writeData, got.d);
        chk("wr_pending", 32'(pending[writeReg]), 32'd1);
      end
    end
  end

  task automatic drive(input logic v0, input logic [4:0] r0,
                       input logic [31:0] d0, input logic v1,
                       input logic [4:0] r1, input logic [31:0] d1,
                       output logic a0, output logic a1);
    @(negedge Clk);
    req0_valid = v0; req0_reg = r0; req0_data = d0;
    req1_valid = v1; req1_reg = r1; req1_data = d1;
    #4;
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    @(posedge Clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  logic a0, a1;
  int   i0, i1;

  initial begin
    req0_valid = 1'b0; req0_reg = '0; req0_data = '0;
    req1_valid = 1'b0; req1_reg = '0; req1_data = '0;

    // reset state
    repeat (2) @(negedge Clk);
    chk("rst_regWrite", 32'(regWrite), 32'd0);
    chk("rst_writeReg", 32'(writeReg), 32'd0);
    chk("rst_writeData", writeData, 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;

    // fill r8/r9, then reset while r8 is on the output
    drive(1'b1, 5'd8, 32'h0808, 1'b1, 5'd9, 32'h0909, a0, a1);
    chk("fill_acc", 32'({a0, a1}), 32'd3);
    @(posedge Clk);
    #1;
    chk("pre_rst_regWrite", 32'(regWrite), 32'd1);
    #1;
    Rst = 1'b1;
    #1;
    chk("mid_rst_regWrite", 32'(regWrite), 32'd0);
    chk("mid_rst_pending", pending, 32'd0);
    #2;
    Rst = 1'b0;
    idle(4);
    chk("mid_rst_r8", rf[8], 32'h0);
    chk("mid_rst_r9", rf[9], 32'h0);

    // single write latency
    push(5'd10, 32'h11112222);
    drive(1'b1, 5'd10, 32'h11112222, 1'b0, 5'd0, 32'h0, a0, a1);
    chk("single_acc", 32'(a0), 32'd1);
    @(negedge Clk);
    chk("single_n_regWrite", 32'(regWrite), 32'd0);
    @(negedge Clk);
    chk("single_n1_regWrite", 32'(regWrite), 32'd1);
    chk("single_n1_writeReg", 32'(writeReg), 32'd10);
    chk("single_n1_pending", pending, 32'h0000_0400);
    @(negedge Clk);
    chk("single_n2_regWrite", 32'(regWrite), 32'd0);
    chk("single_n2_pending", pending, 32'd0);
    idle(1);
    chk("single_r10", rf[10], 32'h11112222);

    // simultaneous different targets from reset
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    push(5'd8, 32'hAAAA0000);
    push(5'd9, 32'hBBBB0000);
    drive(1'b1, 5'd8, 32'hAAAA0000, 1'b1, 5'd9, 32'hBBBB0000, a0, a1);
    chk("dual_acc", 32'({a0, a1}), 32'd3);
    @(negedge Clk);
    chk("dual_wait_ready1", 32'(req1_ready), 32'd0);
    chk("dual_wait_ready0", 32'(req0_ready), 32'd1);
    @(negedge Clk);
    chk("dual_grant_ready1", 32'(req1_ready), 32'd1);
    idle(3);
    chk("dual_r8", rf[8], 32'hAAAA0000);
    chk("dual_r9", rf[9], 32'hBBBB0000);

    // streaming both ports, distinct registers
    for (int i = 0; i < 5; i++) begin
      push(5'(1 + i), 32'hA000_0000 + 32'(i));
      push(5'(16 + i), 32'hB000_0000 + 32'(i));
    end
    i0 = 0;
    i1 = 0;
    for (int k = 0; k < 20 && (i0 < 5 || i1 < 5); k++) begin
      @(negedge Clk);
      req0_valid = (i0 < 5);
      req0_reg   = 5'(1 + i0);
      req0_data  = 32'hA000_0000 + 32'(i0);
      req1_valid = (i1 < 5);
      req1_reg   = 5'(16 + i1);
      req1_data  = 32'hB000_0000 + 32'(i1);
      #4;
      if (k >= 1) begin
        chk("stream_ready0", 32'(req0_ready), 32'(k % 2));
        chk("stream_ready1", 32'(req1_ready), 32'((k + 1) % 2));
      end
      if (k >= 2)
        chk("stream_regWrite", 32'(regWrite), 32'd1);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge Clk);
      #1;
      if (a0) i0++;
      if (a1) i1++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("stream_count", 32'(i0 + i1), 32'd10);
    idle(4);

    // same-register tie: age wins over round-robin
    push(5'd3, 32'h33);
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0, a0, a1);
    idle(3);
    push(5'd5, 32'h1);
    push(5'd5, 32'h2);
    drive(1'b1, 5'd5, 32'h1, 1'b1, 5'd5, 32'h2, a0, a1);
    chk("tie_acc", 32'({a0, a1}), 32'd3);
    idle(4);
    chk("tie_r5", rf[5], 32'h2);

    // register zero
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEADBEEF, a0, a1);
    chk("zero_acc", 32'(a1), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk("zero_regWrite", 32'(regWrite), 32'd0);
      chk("zero_pending", pending, 32'd0);
    end
    chk("zero_ready1", 32'(req1_ready), 32'd1);

    idle(2);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the processor's 32x32 register file (`registers`) between two writeback requesters: port 0 (ALU result) and port 1 (load / multi-cycle unit result). Each requester hands off a (register, data) pair over a valid/ready handshake into a one-entry holding slot. The arbiter grants one slot per cycle and drives the registered `regWrite`/`writeReg`/`writeData` inputs of the register file. It also publishes a pending-write mask so the control unit can stall reads of registers whose writes have not yet committed.

## Interface
- DATA_W, 32, data width
- ADDR_W, 5, register index width; the register file holds 2**ADDR_W entries
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous reset, active-high
- req0_valid  in  1  port 0 write request
- req0_reg  in  ADDR_W  port 0 destination register
- req0_data  in  DATA_W  port 0 write data
- req0_ready  out  1  port 0 slot can accept this cycle
- req1_valid, req1_reg, req1_data, req1_ready  same as port 0, for port 1
- regWrite  out  1  write enable to the register file (registered)
- writeReg  out  ADDR_W  write address to the register file (registered)
- writeData  out  DATA_W  write data to the register file (registered)
- pending  out  2**ADDR_W  bit r = 1 when a held slot or the current output targets register r

## Operation
- Transfer on port p when reqp_valid && reqp_ready at a rising edge.
- reqp_ready = !Rst && (slot p empty || slot p granted this cycle). A granted slot can be refilled at the same edge, giving back-to-back throughput.
- Register 0 is hardwired zero. A transfer with reqp_reg == 0 completes the handshake but does not fill the slot, is never granted, and never sets `pending`.
- Age: each slot records its fill order. If both slots fill at the same edge, slot 0 is older.
- Grant selection, evaluated each cycle over full slots:
  - only one slot full: grant it.
  - both full with the same target register: grant the older slot.
  - both full with different targets: round-robin, grant the port that is not `last_grant`.
- Any grant updates `last_grant` to the granted port.
- On a grant, the next edge loads `regWrite`=1 and `writeReg`/`writeData` from the granted slot, and clears that slot unless it is refilled at the same edge.
- With no grant, the next edge sets `regWrite`=0. `writeReg` and `writeData` hold their previous values.
- `pending` is combinational: the OR of the decoded targets of full slots, plus `writeReg` when `regWrite`=1. Bit 0 is always 0.

## Timing
- Reset (asynchronous, while Rst=1):
  - both slots empty, `last_grant`=1 (port 0 wins the first round-robin),
  - `regWrite`=0, `writeReg`=0, `writeData`=0,
  - `pending`=0, both readies 0.
- Rst asserted mid-operation discards held slots and any in-flight output immediately; no partial write reaches the register file.
- Latency:
  - accept at edge N; if granted in cycle N..N+1, `regWrite`=1 during cycle N+1..N+2;
  - the register file commits at edge N+2.
- A slot that loses arbitration waits at most one grant, because two slots and round-robin/age ordering bound the wait.
- `regWrite` is high for exactly one cycle per granted entry.
- Sustained throughput: one register write per cycle total. With both ports streaming, each port gets one write per two cycles.
- Final value of a register written by both ports: the younger entry's data is written last.

## Test plan
- Reset: hold Rst=1 → all outputs 0, both readies 0. Release, then fill both slots with r8/r9. Assert Rst for 3 ns mid-cycle → `regWrite`=0 and `pending`=0 immediately, and no write occurs after release.
- Single write: req0 r10 = 32'h11112222 accepted at edge N → during cycle N+1, `regWrite`=1, `writeReg`=10, `writeData`=32'h11112222, `pending`[10]=1. During cycle N+2, `regWrite`=0 and `pending`=0. A `registers` instance read of r10 returns 32'h11112222 after edge N+2.
- Simultaneous different targets from reset: req0 r8=32'hAAAA0000, req1 r9=32'hBBBB0000 at the same edge → r8 written first, then r9 next cycle. req1_ready=0 for the one cycle its slot waits.
- Streaming: both ports valid every cycle for 10 cycles with distinct registers → grants alternate 0,1,0,1…, `regWrite` is continuously 1, and each ready toggles in step with its grants.
- Same-target tie: force `last_grant`=0 via a prior port-0 write, then req0 r5=32'h1 and req1 r5=32'h2 at the same edge → slot 0 is written first (age overrides round-robin), and r5 finally reads 32'h2.
- Zero register: req1 r0=32'hDEADBEEF → handshake completes, `regWrite` stays 0, `pending`=0, and r0 reads 0.
